// File: rtl/rc_tick_timer.sv
// Interval timer counting ripple-carry ticks from the upstream 4-bit counter.
// Supports one-shot and periodic modes, with a sticky irq, ack and overrun flag.
module rc_tick_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Rc,
  input  logic [3:0]   Q_lo,
  input  logic         start,
  input  logic         stop,
  input  logic         clr,
  input  logic [W-1:0] period,
  input  logic         mode,
  input  logic         ack,
  output logic [W-1:0] tick_cnt,
  output logic [W+3:0] elapsed,
  output logic         expire,
  output logic         irq,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] period_reg, period_nxt;
  logic [W-1:0] cnt_nxt;
  logic         mode_reg, mode_nxt;
  logic         fire;
  logic         accept;

  // An Rc arriving alongside any command is swallowed by the command.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = tick_cnt;
    period_nxt = period_reg;
    mode_nxt   = mode_reg;
    fire       = 1'b0;
    accept     = start && (period != '0) && (state != RUN);

    if (clr) begin
      cnt_nxt   = '0;
      state_nxt = IDLE;
    end else if (stop) begin
      if (state == RUN) state_nxt = IDLE;
    end else if (accept) begin
      period_nxt = period;
      mode_nxt   = mode;
      cnt_nxt    = '0;
      state_nxt  = RUN;
    end else if ((state == RUN) && Rc) begin
      if (tick_cnt == period_reg - W'(1)) begin
        fire = 1'b1;
        if (mode_reg) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt   = period_reg;
          state_nxt = DONE;
        end
      end else begin
        cnt_nxt = tick_cnt + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      period_reg <= '0;
      mode_reg   <= 1'b0;
      expire     <= 1'b0;
      irq        <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick_cnt   <= cnt_nxt;
      period_reg <= period_nxt;
      mode_reg   <= mode_nxt;
      expire     <= fire;
      // A fire in the same cycle as ack wins, so the flag stays set.
      irq        <= fire | (irq & ~ack);
      ovf        <= ovf | (fire & irq);
      busy       <= (state_nxt == RUN);
      done       <= (state_nxt == DONE);
    end
  end

  assign elapsed = {tick_cnt, Q_lo};

endmodule

// File: tb/tb_rc_tick_timer.sv
// Bench for rc_tick_timer: free-running upstream counter, tick-count model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_rc_tick_timer;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   q_lo = 4'd0;
  logic         rc;
  logic         start = 1'b0, stop = 1'b0, clr = 1'b0, mode = 1'b0, ack = 1'b0;
  logic [W-1:0] period = '0;
  logic [W-1:0] tick_cnt;
  logic [W+3:0] elapsed;
  logic         expire, irq, ovf, busy, done;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  rc_tick_timer #(.W(W)) dut (
    .clk(clk), .rst(rst), .Rc(rc), .Q_lo(q_lo), .start(start), .stop(stop),
    .clr(clr), .period(period), .mode(mode), .ack(ack), .tick_cnt(tick_cnt),
    .elapsed(elapsed), .expire(expire), .irq(irq), .ovf(ovf), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Upstream free-running 4-bit counter.
  always @(posedge clk) q_lo <= q_lo + 4'd1;
  assign rc = (q_lo == 4'd15);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: count ticks since start; tick_cnt is derived from that count.
  int m_st = 0;      // 0 idle, 1 run, 2 done
  int m_ticks = 0;
  int m_p = 0;
  bit m_mode = 0, m_exp = 0, m_irq = 0, m_ovf = 0;

  always @(posedge clk) begin
    int st, tk, p;
    bit md, f;
    st = m_st; tk = m_ticks; p = m_p; md = m_mode; f = 0;
    if (rst) begin
      m_st <= 0; m_ticks <= 0; m_p <= 0; m_mode <= 0;
      m_exp <= 0; m_irq <= 0; m_ovf <= 0;
    end else begin
      if (clr) begin
        tk = 0; st = 0;
      end else if (stop) begin
        if (st == 1) st = 0;
      end else if (start && period != 0 && st != 1) begin
        p = int'(period); md = mode; tk = 0; st = 1;
      end else if (st == 1 && rc) begin
        tk++;
        if (tk % p == 0) begin
          f = 1;
          if (!md) st = 2;
        end
      end
      m_st <= st; m_ticks <= tk; m_p <= p; m_mode <= md;
      m_exp <= f;
      m_ovf <= m_ovf | (f & m_irq);
      m_irq <= f | (m_irq & !ack);
    end
  end

  function automatic int mcnt();
    if (m_p == 0) return 0;
    return m_mode ? (m_ticks % m_p) : m_ticks;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_tick_cnt", 32'(tick_cnt), 32'(mcnt()));
      chk("m_elapsed", 32'(elapsed), 32'({mcnt()[W-1:0], q_lo}));
      chk("m_expire", 32'(expire), 32'(m_exp));
      chk("m_irq", 32'(irq), 32'(m_irq));
      chk("m_ovf", 32'(ovf), 32'(m_ovf));
      chk("m_busy", 32'(busy), 32'(m_st == 1));
      chk("m_done", 32'(done), 32'(m_st == 2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int p, input bit m);
    period = W'(p); mode = m; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic wait_expire(input int maxc, input string nm);
    int n = 0;
    do begin step(); n++; end while (!expire && n < maxc);
    chk(nm, 32'(expire), 32'd1);
  endtask

  task automatic wait_cnt(input int val, input int maxc, input string nm);
    int n = 0;
    while (int'(tick_cnt) != val && n < maxc) begin step(); n++; end
    chk(nm, 32'(tick_cnt), 32'(val));
  endtask

  task automatic wait_rc_next(input int maxc);
    int n = 0;
    while (q_lo != 4'd15 && n < maxc) begin step(); n++; end
    chk("rc_phase", 32'(q_lo), 32'd15);
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_tick", 32'(tick_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    // Periodic P=3: pulses 48 clocks apart, tick_cnt 0,1,2,0.
    do_start(3, 1'b1);
    wait_expire(60, "per_first_expire");
    chk("per_cnt0", 32'(tick_cnt), 32'd0);
    repeat (16) step();
    chk("per_cnt1", 32'(tick_cnt), 32'd1);
    chk("per_busy", 32'(busy), 32'd1);
    repeat (16) step();
    chk("per_cnt2", 32'(tick_cnt), 32'd2);
    repeat (16) step();
    chk("per_cnt_wrap", 32'(tick_cnt), 32'd0);
    chk("per_expire_48", 32'(expire), 32'd1);
    pulse_clr();

    // One-shot P=2.
    do_start(2, 1'b0);
    wait_expire(40, "os_expire");
    chk("os_done", 32'(done), 32'd1);
    chk("os_busy", 32'(busy), 32'd0);
    chk("os_cnt", 32'(tick_cnt), 32'd2);
    repeat (40) step();
    chk("os_hold", 32'(tick_cnt), 32'd2);
    pulse_clr();

    // Stop after 5 ticks, then restart with P=1.
    do_start(10, 1'b0);
    wait_cnt(5, 200, "stop_reach5");
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    repeat (20) step();
    chk("stop_hold", 32'(tick_cnt), 32'd5);
    do_start(1, 1'b0);
    chk("restart_cnt", 32'(tick_cnt), 32'd0);
    wait_expire(20, "restart_expire");
    pulse_clr();

    // start with period 0 is ignored.
    do_start(0, 1'b1);
    chk("p0_busy", 32'(busy), 32'd0);

    // clr+stop+start together.
    do_start(4, 1'b1);
    repeat (40) step();
    period = W'(4); clr = 1'b1; stop = 1'b1; start = 1'b1;
    step();
    clr = 1'b0; stop = 1'b0; start = 1'b0;
    chk("css_busy", 32'(busy), 32'd0);
    chk("css_cnt", 32'(tick_cnt), 32'd0);

    // Overrun with P=1 periodic.
    rst = 1'b1; step(); rst = 1'b0;
    chk("ovf_rst", 32'(ovf), 32'd0);
    do_start(1, 1'b1);
    wait_expire(20, "ovf_exp1");
    chk("ovf_irq1", 32'(irq), 32'd1);
    chk("ovf_still0", 32'(ovf), 32'd0);
    wait_expire(20, "ovf_exp2");
    chk("ovf_set", 32'(ovf), 32'd1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_irq", 32'(irq), 32'd0);
    chk("ack_ovf", 32'(ovf), 32'd1);

    // ack in the same cycle as the fire keeps irq set.
    wait_rc_next(20);
    ack = 1'b1; step(); ack = 1'b0;
    chk("ackfire_expire", 32'(expire), 32'd1);
    chk("ackfire_irq", 32'(irq), 32'd1);
    pulse_clr();

    // Reset on the cycle of the final tick drops the expire.
    do_start(8, 1'b0);
    wait_cnt(7, 200, "rst_reach7");
    wait_rc_next(20);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rstrun_expire", 32'(expire), 32'd0);
    chk("rstrun_cnt", 32'(tick_cnt), 32'd0);
    chk("rstrun_busy", 32'(busy), 32'd0);
    chk("rstrun_irq", 32'(irq), 32'd0);
    chk("rstrun_ovf", 32'(ovf), 32'd0);
    repeat (20) step();
    chk("rstrun_quiet", 32'(expire), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rc_tick_timer.md
# rc_tick_timer

Programmable interval timer that sits directly downstream of the 4-bit free-running counter and consumes its ripple-carry output. Each Rc pulse (one clock wide, once every 16 clocks) is one timer tick. The block counts ticks against a software-loaded period in one-shot or periodic mode. It raises a registered expire pulse and a sticky interrupt flag with acknowledge and overrun detection.

## Interface

Parameters
- W, default 12: tick counter and period width.

Ports (one clock; reset is synchronous and active-high)
- clk  in  1  system clock, rising edge; same clock as the upstream 4-bit counter
- rst  in  1  synchronous, active-high reset
- Rc  in  1  upstream ripple carry; high for exactly one cycle when the upstream count is 15
- Q_lo  in  4  upstream count {Qd,Qc,Qb,Qa}; Qa is the LSB; used only for the elapsed output
- start  in  1  one-cycle command: latch period/mode and begin counting
- stop  in  1  one-cycle command: halt counting and hold the tick count
- clr  in  1  one-cycle command: zero the tick count and return to IDLE
- period  in  W  ticks per interval; sampled only on an accepted start
- mode  in  1  0 = one-shot, 1 = periodic; sampled only on an accepted start
- ack  in  1  clears irq
- tick_cnt  out  W  ticks counted in the current interval
- elapsed  out  W+4  {tick_cnt, Q_lo}, combinational
- expire  out  1  one-cycle registered pulse at interval end
- irq  out  1  sticky expire flag
- ovf  out  1  sticky overrun flag: an expire occurred while irq was still set
- busy  out  1  high in RUN
- done  out  1  high in DONE

## Operation

- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: tick_cnt=0, period_reg=0, mode_reg=0, expire=0, irq=0, ovf=0, busy=0, done=0.
- Command priority per cycle: rst > clr > stop > start > Rc tick.
- IDLE:
  - start with period≠0: period_reg←period, mode_reg←mode, tick_cnt←0, go to RUN.
  - start with period=0 is ignored; the block stays in IDLE and nothing changes.
- RUN, Rc=1, tick_cnt≠period_reg−1: tick_cnt increments.
- RUN, Rc=1, tick_cnt==period_reg−1:
  - expire←1.
  - periodic: tick_cnt←0, stay in RUN.
  - one-shot: tick_cnt←period_reg, go to DONE.
- RUN, stop: go to IDLE with tick_cnt frozen. A subsequent start restarts from 0; there is no resume.
- RUN, start: ignored.
- DONE:
  - Holds tick_cnt; done=1.
  - start with period≠0 behaves as in IDLE.
  - clr goes to IDLE.
- clr in any state: tick_cnt←0, go to IDLE. irq, ovf, period_reg and mode_reg are not affected.
- irq: set on expire. ack clears it. If expire and ack occur in the same cycle, irq stays set.
- ovf: set when expire occurs while irq is already 1, with or without ack in that cycle. Cleared only by rst.
- Arithmetic: tick_cnt is unsigned W-bit. The maximum period is 2^W−1 ticks. No wrap occurs because the compare fires first.
- elapsed is informational. Q_lo is not synchronized to start, so the phase within a tick is arbitrary.

## Timing

- Rc is sampled on the rising edge of clk. All outputs except elapsed are registered.
- expire is high in the cycle after the edge that sampled the final Rc. From then on, the upstream Q_lo reads 0.
- Interval length: with Rc every 16 clocks, period P gives expire pulses exactly 16·P clocks apart in periodic mode, with no cycle slip across reloads.
- First-interval length: the first expire comes between 16·(P−1)+1 and 16·P clocks after start, depending on the upstream phase.
- Rc in the same cycle as an accepted start is not counted.
- busy and done change in the cycle after the command edge.
- rst asserted mid-RUN: all outputs are at their reset values the next cycle, and a pending expire is dropped.

## Test plan

- Periodic, P=3, free-running Rc every 16 clocks:
  - expire pulses are exactly 48 clocks apart.
  - tick_cnt sequence is 0,1,2,0.
  - busy stays 1.
- One-shot, P=2:
  - after the 2nd Rc, expire pulses once; done=1, busy=0, tick_cnt=2.
  - further Rc pulses leave tick_cnt at 2 with no further expire.
- Stop after 5 ticks with P=10: tick_cnt holds 5 in IDLE. A later start (P=1) gives tick_cnt=0, and the first Rc produces expire.
- Leave irq set (no ack) with periodic P=1: the 2nd expire sets ovf=1. An ack then clears irq but ovf stays 1 until rst.
- Simultaneous events:
  - start with period=0 is ignored: stays IDLE.
  - clr+stop+start in the same cycle gives IDLE with tick_cnt=0.
  - expire with ack in the same cycle leaves irq=1.
- Assert rst during RUN at tick_cnt=7, including the cycle where Rc fires on the final tick: all outputs return to reset values and no expire is issued.
